block_packer_nch: RTL and testbench

//  N-channel successor of the 2-input block shifter. Each channel delivers up to MAX_NUM_BLOCKS

---
 rtl/block_packer_nch.sv | 212 +++++++++++++++++++++
 tb/tb_block_packer_nch.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/block_packer_nch.sv
// N-channel block packer: each channel fills a one-deep slot, and the present slots are
// packed densely, in ascending channel order, into one registered output beat.

module block_packer_nch_slot #(
    parameter int BLOCK_SIZE     = 64,
    parameter int MAX_NUM_BLOCKS = 2,
    parameter int NW             = 2
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       in_valid,
    input  logic [MAX_NUM_BLOCKS*BLOCK_SIZE-1:0]       in_data,
    input  logic [31:0]                                in_num,
    input  logic                                       in_last,
    input  logic                                       clr,
    output logic                                       in_ready,
    output logic                                       cap,
    output logic                                       over,
    output logic                                       full,
    output logic [MAX_NUM_BLOCKS-1:0][BLOCK_SIZE-1:0]  blk,
    output logic [NW-1:0]                              num,
    output logic                                       last
);
    logic ovf;

    assign ovf      = in_num > 32'(MAX_NUM_BLOCKS);
    assign cap      = in_valid & ~full;
    assign in_ready = ~full & ~rst;
    assign over     = cap & ovf;

    // A capture only hits an empty slot, so it never collides with a pack clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            blk  <= '0;
            num  <= '0;
            last <= 1'b0;
        end else if (cap) begin
            full <= 1'b1;
            blk  <= in_data;
            num  <= ovf ? NW'(MAX_NUM_BLOCKS) : in_num[NW-1:0];
            last <= in_last;
        end else if (clr) begin
            full <= 1'b0;
        end
    end
endmodule

module block_packer_nch #(
    parameter int BLOCK_SIZE     = 64,
    parameter int MAX_NUM_BLOCKS = 2,
    parameter int NUM_CH         = 4,
    parameter int TIMEOUT_CYC    = 16
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [NUM_CH-1:0]                                 in_valid,
    output logic [NUM_CH-1:0]                                 in_ready,
    input  logic [NUM_CH-1:0][MAX_NUM_BLOCKS*BLOCK_SIZE-1:0]  in_data,
    input  logic [NUM_CH-1:0][31:0]                           in_num,
    input  logic [NUM_CH-1:0]                                 in_last,
    input  logic                                              flush,
    input  logic                                              out_ready,
    output logic                                              out_valid,
    output logic [NUM_CH*MAX_NUM_BLOCKS*BLOCK_SIZE-1:0]       out_data,
    output logic [31:0]                                       out_num,
    output logic                                              out_last,
    output logic                                              err_num
);
    localparam int NB = NUM_CH * MAX_NUM_BLOCKS;
    localparam int NW = $clog2(MAX_NUM_BLOCKS + 1);
    localparam int OW = $clog2(NB + 1);
    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, STALL} state_t;

    state_t state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic          pack;

    logic [NUM_CH-1:0]                                 slot_full, slot_last, cap, over;
    logic [NUM_CH-1:0][NW-1:0]                         slot_num;
    logic [NUM_CH-1:0][MAX_NUM_BLOCKS-1:0][BLOCK_SIZE-1:0] slot_blk;
    logic [NUM_CH-1:0]                                 done, done_n;

    logic [NUM_CH-1:0][OW-1:0] off;
    logic [OW-1:0]             total;
    logic [NB-1:0][BLOCK_SIZE-1:0] pk_blk;

    logic any_cap, out_free, timeout_hit, pack_req;

    genvar gc;
    generate
        for (gc = 0; gc < NUM_CH; gc++) begin : g_slot
            block_packer_nch_slot #(
                .BLOCK_SIZE     (BLOCK_SIZE),
                .MAX_NUM_BLOCKS (MAX_NUM_BLOCKS),
                .NW             (NW)
            ) u_slot (
                .clk      (clk),
                .rst      (rst),
                .in_valid (in_valid[gc]),
                .in_data  (in_data[gc]),
                .in_num   (in_num[gc]),
                .in_last  (in_last[gc]),
                .clr      (pack),
                .in_ready (in_ready[gc]),
                .cap      (cap[gc]),
                .over     (over[gc]),
                .full     (slot_full[gc]),
                .blk      (slot_blk[gc]),
                .num      (slot_num[gc]),
                .last     (slot_last[gc])
            );
        end
    endgenerate

    assign any_cap     = |cap;
    assign out_free    = ~out_valid | out_ready;
    assign timeout_hit = (TIMEOUT_CYC != 0) && (timer == TW'(TIMEOUT_CYC));
    // Channels already done no longer hold up a pack.
    assign pack_req    = (&(slot_full | done)) | flush | timeout_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_n;
            timer <= timer_n;
        end
    end

    always_comb begin
        state_n = state;
        timer_n = timer;
        pack    = 1'b0;
        case (state)
            IDLE: begin
                if (any_cap) begin
                    state_n = COLLECT;
                    timer_n = '0;
                end
            end
            COLLECT: begin
                if (pack_req && out_free) begin
                    pack    = 1'b1;
                    state_n = any_cap ? COLLECT : IDLE;
                    timer_n = '0;
                end else if (pack_req) begin
                    state_n = STALL;
                end else if (timer != TW'(TIMEOUT_CYC)) begin
                    timer_n = timer + 1'b1;
                end
            end
            STALL: begin
                if (out_free) begin
                    pack    = 1'b1;
                    state_n = any_cap ? COLLECT : IDLE;
                    timer_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Each full slot lands right after the blocks of the lower full slots.
    always_comb begin
        off[0] = '0;
        for (int c = 1; c < NUM_CH; c++)
            off[c] = off[c-1] + (slot_full[c-1] ? OW'(slot_num[c-1]) : OW'(0));
        total = off[NUM_CH-1] + (slot_full[NUM_CH-1] ? OW'(slot_num[NUM_CH-1]) : OW'(0));
    end

    always_comb begin
        pk_blk = '0;
        for (int j = 0; j < NB; j++)
            for (int c = 0; c < NUM_CH; c++)
                for (int k = 0; k < MAX_NUM_BLOCKS; k++)
                    if (slot_full[c] && (NW'(k) < slot_num[c]) && (off[c] + OW'(k) == OW'(j)))
                        pk_blk[j] = slot_blk[c][k];
    end

    // Clearing on an out_last transfer comes first so a same-edge pack can re-mark channels.
    always_comb begin
        done_n = (out_valid && out_ready && out_last) ? '0 : done;
        if (pack)
            done_n = done_n | (slot_full & slot_last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_num   <= '0;
            out_last  <= 1'b0;
            done      <= '0;
            err_num   <= 1'b0;
        end else begin
            if (pack) begin
                out_valid <= 1'b1;
                out_data  <= pk_blk;
                out_num   <= 32'(total);
                out_last  <= &done_n;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            done    <= done_n;
            err_num <= err_num | (|over);
        end
    end
endmodule

// File: tb/tb_block_packer_nch.sv
// Directed bench for block_packer_nch: expected beats are queued at stimulus time
// and popped by a monitor whenever an output beat transfers.

module tb_block_packer_nch;
    localparam int BS  = 64;
    localparam int MX  = 2;
    localparam int NC  = 4;
    localparam int TO  = 16;
    localparam int DW  = NC * MX * BS;

    logic                           clk = 1'b0;
    logic                           rst = 1'b1;
    logic [NC-1:0]                  in_valid = '0;
    logic [NC-1:0]                  in_ready;
    logic [NC-1:0][MX*BS-1:0]       in_data = '0;
    logic [NC-1:0][31:0]            in_num = '0;
    logic [NC-1:0]                  in_last = '0;
    logic                           flush = 1'b0;
    logic                           out_ready = 1'b1;
    logic                           out_valid;
    logic [DW-1:0]                  out_data;
    logic [31:0]                    out_num;
    logic                           out_last;
    logic                           err_num;

    block_packer_nch #(
        .BLOCK_SIZE(BS), .MAX_NUM_BLOCKS(MX), .NUM_CH(NC), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_num(in_num), .in_last(in_last), .flush(flush),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_num(out_num), .out_last(out_last), .err_num(err_num)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        int            n;
        logic          l;
    } beat_t;

    beat_t       sb[$];
    int          checks = 0;
    int          passed = 0;
    int          tb_num [NC];
    logic [BS-1:0] tb_blk [NC][MX];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic setch(input int c, input int n);
        tb_num[c] = n;
        for (int k = 0; k < MX; k++)
            tb_blk[c][k] = {8'hc0 + 8'(c), 8'(k), 16'(n), $urandom()};
    endtask

    // Drive the masked channels for one edge; slots are empty, so that edge captures.
    task automatic send(input logic [NC-1:0] mask, input logic [NC-1:0] lmask);
        for (int c = 0; c < NC; c++) begin
            in_valid[c] = mask[c];
            in_data[c]  = {tb_blk[c][1], tb_blk[c][0]};
            in_num[c]   = tb_num[c];
            in_last[c]  = lmask[c];
        end
        @(posedge clk); #1;
        in_valid = '0;
        in_last  = '0;
    endtask

    task automatic expect_beat(input logic [NC-1:0] mask, input logic last);
        beat_t b;
        int    pos;
        b.d = '0;
        pos = 0;
        for (int c = 0; c < NC; c++) begin
            if (mask[c]) begin
                for (int k = 0; k < ((tb_num[c] > MX) ? MX : tb_num[c]); k++) begin
                    b.d[pos*BS +: BS] = tb_blk[c][k];
                    pos++;
                end
            end
        end
        b.n = pos;
        b.l = last;
        sb.push_back(b);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0 && !out_valid) break;
            @(posedge clk); #1;
        end
        chk(tag, (sb.size() == 0 && !out_valid), 1);
    endtask

    always @(negedge clk) begin
        beat_t b;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                b = sb.pop_front();
                chk("beat_data", out_data, b.d);
                chk("beat_num", out_num, b.n);
                chk("beat_last", out_last, b.l);
            end
        end
    end

    initial begin
        logic [DW-1:0] snap_d;
        logic [31:0]   snap_n;
        int            n;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_num", out_num, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_err_num", err_num, 0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", in_ready, 4'hf);

        // dense packing with a zero-count channel; one-cycle latency
        setch(0, 2); setch(1, 1); setch(2, 0); setch(3, 2);
        expect_beat(4'b1111, 1'b0);
        send(4'b1111, 4'b0000);
        chk("t1_not_yet", out_valid, 0);
        @(posedge clk); #1;
        chk("t1_latency", out_valid, 1);
        chk("t1_num", out_num, 5);
        drain("t1_drain");

        // single channel: timeout path
        setch(1, 2);
        expect_beat(4'b0010, 1'b0);
        send(4'b0010, 4'b0000);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin n = i; break; end
        end
        chk("t2_timeout_edges", n, TO + 1);
        drain("t2_drain");

        // single channel: flush path
        setch(1, 2);
        expect_beat(4'b0010, 1'b0);
        send(4'b0010, 4'b0000);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("t2_flush_latency", out_valid, 1);
        drain("t2f_drain");

        // backpressure with refill
        out_ready = 1'b0;
        setch(0, 1); setch(1, 2); setch(2, 1); setch(3, 1);
        expect_beat(4'b1111, 1'b0);
        send(4'b1111, 4'b0000);
        @(posedge clk); #1;
        snap_d = out_data;
        snap_n = out_num;
        chk("t3_pending", out_valid, 1);
        setch(0, 2); setch(1, 0); setch(2, 2); setch(3, 1);
        expect_beat(4'b1111, 1'b0);
        send(4'b1111, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("t3_stable_data", out_data, snap_d);
            chk("t3_stable_num", out_num, snap_n);
            chk("t3_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t3_second_valid", out_valid, 1);
        chk("t3_second_num", out_num, 5);
        drain("t3_drain");

        // staggered last flags
        setch(0, 1);
        expect_beat(4'b0001, 1'b0);
        send(4'b0001, 4'b0001);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        drain("t4a_drain");
        setch(1, 2); setch(2, 1);
        expect_beat(4'b0110, 1'b0);
        send(4'b0110, 4'b0010);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        drain("t4b_drain");
        setch(2, 1); setch(3, 2);
        expect_beat(4'b1100, 1'b1);
        send(4'b1100, 4'b1100);
        @(posedge clk); #1;
        chk("t4c_live_pack", out_valid, 1);
        drain("t4c_drain");
        setch(0, 1);
        send(4'b0001, 4'b0000);
        repeat (5) @(posedge clk);
        #1;
        chk("t4d_waits_for_all", out_valid, 0);
        setch(1, 1); setch(2, 2); setch(3, 1);
        expect_beat(4'b1111, 1'b0);
        send(4'b1110, 4'b0000);
        drain("t4d_drain");

        // oversized count
        chk("t5_err_before", err_num, 0);
        setch(0, 1); setch(1, 1); setch(2, 7); setch(3, 0);
        expect_beat(4'b1111, 1'b0);
        send(4'b1111, 4'b0000);
        chk("t5_err_set", err_num, 1);
        drain("t5_drain");
        repeat (3) @(posedge clk);
        #1;
        chk("t5_err_sticky", err_num, 1);

        // asynchronous reset during STALL
        out_ready = 1'b0;
        setch(0, 2); setch(1, 2); setch(2, 2); setch(3, 2);
        send(4'b1111, 4'b0000);
        @(posedge clk); #1;
        send(4'b1111, 4'b0000);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        chk("t6_out_valid", out_valid, 0);
        chk("t6_in_ready", in_ready, 0);
        chk("t6_err_num", err_num, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        setch(0, 1); setch(1, 2); setch(2, 0); setch(3, 1);
        expect_beat(4'b1111, 1'b0);
        send(4'b1111, 4'b0000);
        @(posedge clk); #1;
        chk("t6_repack_num", out_num, 4);
        drain("t6_drain");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
